// File: rtl/ap_ppgen_stage.sv
// Registered AND-array partial-product stage for the 8x8 approximate multiplier.
// Output register plus one skid entry allows full throughput under backpressure.
module ap_ppgen_stage #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_pp,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic [CNT_W-1:0] acc_cnt
);

    logic [63:0]      in_pp;
    logic             in_zero;
    logic             in_xfer;
    logic             o_free;

    logic             o_valid;
    logic [63:0]      o_pp;
    logic [TAG_W-1:0] o_tag;
    logic             o_zero;

    logic             s_valid;
    logic [63:0]      s_pp;
    logic [TAG_W-1:0] s_tag;
    logic             s_zero;

    logic             in_ready_r;
    logic [CNT_W-1:0] acc_cnt_r;

    // Row i carries a gated by b[i]; bit weight is 2^(i+j).
    always_comb begin
        in_pp = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                in_pp[8*i+j] = in_a[j] & in_b[i];
            end
        end
    end

    assign in_zero = (in_a == 8'h00) || (in_b == 8'h00);
    assign in_xfer = in_valid && in_ready_r;
    assign o_free  = !o_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_pp       <= '0;
            o_tag      <= '0;
            o_zero     <= 1'b0;
            s_valid    <= 1'b0;
            s_pp       <= '0;
            s_tag      <= '0;
            s_zero     <= 1'b0;
            in_ready_r <= 1'b0;
            acc_cnt_r  <= '0;
        end else begin
            if (in_xfer) begin
                acc_cnt_r <= acc_cnt_r + CNT_W'(1);
            end
            if (o_free) begin
                if (s_valid) begin
                    // Skid entry is older than anything arriving now, so it drains first.
                    o_valid    <= 1'b1;
                    o_pp       <= s_pp;
                    o_tag      <= s_tag;
                    o_zero     <= s_zero;
                    s_valid    <= in_xfer;
                    in_ready_r <= !in_xfer;
                    if (in_xfer) begin
                        s_pp   <= in_pp;
                        s_tag  <= in_tag;
                        s_zero <= in_zero;
                    end
                end else begin
                    o_valid    <= in_xfer;
                    in_ready_r <= 1'b1;
                    if (in_xfer) begin
                        o_pp   <= in_pp;
                        o_tag  <= in_tag;
                        o_zero <= in_zero;
                    end
                end
            end else begin
                if (in_xfer) begin
                    s_valid <= 1'b1;
                    s_pp    <= in_pp;
                    s_tag   <= in_tag;
                    s_zero  <= in_zero;
                end
                in_ready_r <= !(s_valid || in_xfer);
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = o_valid;
    assign out_pp    = o_pp;
    assign out_tag   = o_tag;
    assign out_zero  = o_zero;
    assign acc_cnt   = acc_cnt_r;

endmodule

// File: tb/tb_ap_ppgen_stage.sv
// Directed and randomized checks of ap_ppgen_stage against a queue reference model.
module tb_ap_ppgen_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pp;
    logic [3:0]  out_tag;
    logic        out_zero;
    logic [15:0] acc_cnt;

    ap_ppgen_stage #(.TAG_W(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pp    (out_pp),
        .out_tag   (out_tag),
        .out_zero  (out_zero),
        .acc_cnt   (acc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pp;
        logic [3:0]  tag;
        logic        zero;
    } txn_t;

    txn_t       mq[$];
    logic [3:0] emitted[$];
    int         checks = 0;
    int         errors = 0;
    int         acc_model = 0;
    logic       in_fire = 1'b0;
    logic       out_fire = 1'b0;

    function automatic logic [63:0] model_pp(input logic [7:0] a, input logic [7:0] b);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                p[8*i+j] = a[j] & b[i];
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", name, obs, exp);
        end
    endtask

    // Evaluate the handshakes about to happen at the next edge, then advance.
    task automatic cycle();
        txn_t t;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (out_fire) begin
            if (mq.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                t = mq.pop_front();
                check("model_pp", out_pp, t.pp);
                check("model_tag", {60'd0, out_tag}, {60'd0, t.tag});
                check("model_zero", {63'd0, out_zero}, {63'd0, t.zero});
                emitted.push_back(out_tag);
            end
        end
        if (in_fire && !rst) begin
            t.pp   = model_pp(in_a, in_b);
            t.tag  = in_tag;
            t.zero = (in_a == 8'h00) || (in_b == 8'h00);
            mq.push_back(t);
            acc_model++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cycle();
        mq.delete();
        acc_model = 0;
        in_fire   = 1'b0;
        rst       = 1'b0;
        cycle();
    endtask

    initial begin
        int n;
        int next_tag;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0;
        @(posedge clk); #1;
        cycle();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_pp", out_pp, 64'd0);
        check("rst_acc_cnt", {48'd0, acc_cnt}, 64'd0);
        rst = 1'b0;
        cycle();
        check("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // Basic vectors, one per cycle, out_ready held high.
        out_ready = 1'b1;
        drive(8'hFF, 8'hFF, 4'd1);
        cycle();
        check("ff_valid", {63'd0, out_valid}, 64'd1);
        check("ff_pp", out_pp, 64'hFFFF_FFFF_FFFF_FFFF);
        check("ff_zero", {63'd0, out_zero}, 64'd0);
        check("ff_acc", {48'd0, acc_cnt}, 64'd1);
        drive(8'h01, 8'h80, 4'd2);
        cycle();
        check("b56_pp", out_pp, 64'h0100_0000_0000_0000);
        drive(8'hA5, 8'h03, 4'd3);
        cycle();
        check("a5_pp", out_pp, 64'h0000_0000_0000_A5A5);
        check("a5_tag", {60'd0, out_tag}, 64'd3);
        drive(8'h00, 8'h5A, 4'd4);
        cycle();
        check("zero_pp", out_pp, 64'd0);
        check("zero_flag", {63'd0, out_zero}, 64'd1);
        in_valid = 1'b0;
        cycle();
        check("basic_drained", {63'd0, out_valid}, 64'd0);
        check("basic_acc", {48'd0, acc_cnt}, 64'd4);

        // Backpressure: five back-to-back pairs, four stalled cycles.
        do_reset();
        emitted.delete();
        next_tag = 1;
        drive(8'h11, 8'h21, 4'd1);
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (in_fire) begin
                next_tag++;
                drive(8'h11 * next_tag[7:0], 8'h20 + next_tag[7:0], next_tag[3:0]);
            end
        end
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        check("bp_hold_tag", {60'd0, out_tag}, 64'd1);
        check("bp_hold_pp", out_pp, model_pp(8'h11, 8'h21));
        check("bp_acc", {48'd0, acc_cnt}, 64'd2);
        out_ready = 1'b1;
        n = 0;
        while (emitted.size() < 5 && n < 30) begin
            cycle();
            if (in_fire) begin
                next_tag++;
                if (next_tag <= 5)
                    drive(8'h11 * next_tag[7:0], 8'h20 + next_tag[7:0], next_tag[3:0]);
                else
                    in_valid = 1'b0;
            end
            n++;
        end
        check("bp_emitted", emitted.size(), 64'd5);
        for (int k = 0; k < emitted.size(); k++)
            check("bp_order", {60'd0, emitted[k]}, k + 1);
        check("bp_acc_final", {48'd0, acc_cnt}, 64'd5);

        // Reset with both O and S occupied.
        out_ready = 1'b0;
        drive(8'h33, 8'h44, 4'd7);
        cycle();
        drive(8'h55, 8'h66, 4'd8);
        cycle();
        in_valid = 1'b0;
        check("pre_rst_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        cycle();
        mq.delete();
        acc_model = 0;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("mid_rst_acc", {48'd0, acc_cnt}, 64'd0);
        rst = 1'b0;
        cycle();
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        emitted.delete();
        drive(8'h0F, 8'hF0, 4'd9);
        cycle();
        in_valid = 1'b0;
        check("post_rst_tag", {60'd0, out_tag}, 64'd9);
        cycle();
        check("post_rst_count", emitted.size(), 64'd1);

        // Random stress with valid held until accepted.
        in_fire = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (!in_valid || in_fire) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a     = 8'($urandom_range(0, 255));
                in_b     = 8'($urandom_range(0, 255));
                in_tag   = 4'($urandom_range(0, 15));
            end
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (mq.size() != 0 && n < 10) begin
            cycle();
            n++;
        end
        check("rand_drained", mq.size(), 64'd0);
        check("rand_acc", {48'd0, acc_cnt}, 64'(acc_model % 65536));

        // Counter wrap after 65536 accepts.
        do_reset();
        out_ready = 1'b1;
        drive(8'h12, 8'h34, 4'd0);
        n = 0;
        while (acc_model < 65536 && n < 70000) begin
            cycle();
            if (in_fire) drive(in_a + 8'd1, in_b + 8'd3, in_tag + 4'd1);
            n++;
        end
        check("wrap_accepts", acc_model, 64'd65536);
        check("wrap_zero", {48'd0, acc_cnt}, 64'd0);
        cycle();
        in_valid = 1'b0;
        check("wrap_one", {48'd0, acc_cnt}, 64'd1);
        cycle();
        cycle();
        check("wrap_drained", mq.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
